// File: rtl/rom_sram_ctrl.sv
// Memory-side stage behind the PC stage: turns a registered fetch/load/store
// request into a multi-cycle access on an external asynchronous 32-bit SRAM.
module rom_sram_ctrl #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned SRAM_AW     = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ce_i,
   input  logic               we_i,
   input  logic [31:0]        addr_i,
   input  logic [31:0]        data_i,
   input  logic [7:0]         aluop_i,
   output logic [31:0]        data_o,
   output logic               valid_o,
   output logic               stall_req_o,
   output logic [SRAM_AW-1:0] sram_addr_o,
   inout  wire  [31:0]        sram_data_io,
   output logic               sram_ce_n_o,
   output logic               sram_oe_n_o,
   output logic               sram_we_n_o,
   output logic [3:0]         sram_be_n_o
);

   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;

   localparam logic [1:0] MODE_WORD = 2'd0;
   localparam logic [1:0] MODE_LB   = 2'd1;
   localparam logic [1:0] MODE_LBU  = 2'd2;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD       = 3'd1,
      WR_SETUP = 3'd2,
      WR_PULSE = 3'd3,
      WR_HOLD  = 3'd4,
      DONE     = 3'd5
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [1:0]  lane;
   logic [1:0]  mode;
   logic [31:0] wdata;
   logic        bus_oe;

   logic        unused_addr;
   assign unused_addr = ^addr_i[31:SRAM_AW+2];

   // Selects the addressed byte and extends it according to the latched load mode.
   function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] ln,
                                            input logic [1:0] md);
      logic [7:0] b;
      b = w[{ln, 3'b000} +: 8];
      case (md)
         MODE_LB:  load_ext = {{24{b[7]}}, b};
         MODE_LBU: load_ext = {24'h0, b};
         default:  load_ext = w;
      endcase
   endfunction

   // Stall must be visible in the acceptance cycle, so it is decoded directly.
   assign stall_req_o = ((state == IDLE) && ce_i) ||
                        ((state != IDLE) && (state != DONE));

   // Write data is released whenever the controller is not in a write state.
   assign sram_data_io = bus_oe ? wdata : 32'bz;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= 4'h0;
         lane        <= 2'b00;
         mode        <= MODE_WORD;
         wdata       <= 32'h0;
         bus_oe      <= 1'b0;
         data_o      <= 32'h0;
         valid_o     <= 1'b0;
         sram_addr_o <= '0;
         sram_ce_n_o <= 1'b1;
         sram_oe_n_o <= 1'b1;
         sram_we_n_o <= 1'b1;
         sram_be_n_o <= 4'hF;
      end else begin
         case (state)
            IDLE: begin
               valid_o <= 1'b0;
               if (ce_i) begin
                  sram_addr_o <= addr_i[SRAM_AW+1:2];
                  lane        <= addr_i[1:0];
                  cnt         <= WAIT_LOAD;
                  sram_ce_n_o <= 1'b0;
                  if (aluop_i == EXE_LB_OP)
                     mode <= MODE_LB;
                  else if (aluop_i == EXE_LBU_OP)
                     mode <= MODE_LBU;
                  else
                     mode <= MODE_WORD;
                  if (we_i) begin
                     state  <= WR_SETUP;
                     bus_oe <= 1'b1;
                     if (aluop_i == EXE_SB_OP) begin
                        wdata       <= {4{data_i[7:0]}};
                        sram_be_n_o <= ~(4'b0001 << addr_i[1:0]);
                     end else begin
                        wdata       <= data_i;
                        sram_be_n_o <= 4'h0;
                     end
                  end else begin
                     state       <= RD;
                     sram_oe_n_o <= 1'b0;
                     sram_be_n_o <= 4'h0;
                  end
               end
            end
            RD: begin
               if (cnt == 4'h0) begin
                  data_o      <= load_ext(sram_data_io, lane, mode);
                  valid_o     <= 1'b1;
                  state       <= DONE;
                  sram_ce_n_o <= 1'b1;
                  sram_oe_n_o <= 1'b1;
                  sram_be_n_o <= 4'hF;
               end else begin
                  cnt <= cnt - 4'h1;
               end
            end
            WR_SETUP: begin
               state       <= WR_PULSE;
               cnt         <= WAIT_LOAD;
               sram_we_n_o <= 1'b0;
            end
            WR_PULSE: begin
               if (cnt == 4'h0) begin
                  state       <= WR_HOLD;
                  sram_we_n_o <= 1'b1;
               end else begin
                  cnt <= cnt - 4'h1;
               end
            end
            WR_HOLD: begin
               state       <= DONE;
               valid_o     <= 1'b1;
               bus_oe      <= 1'b0;
               sram_ce_n_o <= 1'b1;
               sram_be_n_o <= 4'hF;
            end
            DONE: begin
               valid_o <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state       <= IDLE;
               valid_o     <= 1'b0;
               bus_oe      <= 1'b0;
               sram_ce_n_o <= 1'b1;
               sram_oe_n_o <= 1'b1;
               sram_we_n_o <= 1'b1;
               sram_be_n_o <= 4'hF;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom_sram_ctrl.sv
// Directed bench for rom_sram_ctrl with a behavioural asynchronous SRAM model.
module tb_rom_sram_ctrl;

   localparam int unsigned W      = 2;
   localparam int unsigned AW     = 20;
   localparam int          BUDGET = 20;

   localparam logic [7:0] OP_LB  = 8'hE0;
   localparam logic [7:0] OP_LBU = 8'hE4;
   localparam logic [7:0] OP_SB  = 8'hE8;
   localparam logic [7:0] OP_LW  = 8'hE3;
   localparam logic [7:0] OP_SW  = 8'hEB;

   typedef struct {
      logic        we;
      logic [7:0]  aluop;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_data;
      logic [31:0] exp_bus;
      logic [3:0]  exp_be;
      logic [31:0] exp_mem;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          ce;
   logic          we;
   logic [31:0]   addr;
   logic [31:0]   wdata;
   logic [7:0]    aluop;
   logic [31:0]   rdata;
   logic          valid;
   logic          stall;
   logic [AW-1:0] sram_addr;
   wire  [31:0]   sram_bus;
   logic          sram_ce_n;
   logic          sram_oe_n;
   logic          sram_we_n;
   logic [3:0]    sram_be_n;

   logic [31:0]   mem [0:1023];
   logic          init_done = 1'b0;
   logic          probe = 1'b0;
   logic          sram_drive;

   int n_checks = 0;
   int n_fail   = 0;

   vec_t vecs [15];

   always #5 clk = ~clk;

   rom_sram_ctrl #(.WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .ce_i         (ce),
      .we_i         (we),
      .addr_i       (addr),
      .data_i       (wdata),
      .aluop_i      (aluop),
      .data_o       (rdata),
      .valid_o      (valid),
      .stall_req_o  (stall),
      .sram_addr_o  (sram_addr),
      .sram_data_io (sram_bus),
      .sram_ce_n_o  (sram_ce_n),
      .sram_oe_n_o  (sram_oe_n),
      .sram_we_n_o  (sram_we_n),
      .sram_be_n_o  (sram_be_n)
   );

   // SRAM model; probe lets the bench drive zeros to prove the DUT has released the bus.
   assign sram_drive = (!sram_ce_n && !sram_oe_n && sram_we_n) || probe;
   assign sram_bus   = sram_drive ? (probe ? 32'h0 : mem[sram_addr[9:0]]) : 32'bz;

   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
         mem[10'h000] <= 32'h3C010001;
         mem[10'h001] <= 32'h34210002;
         mem[10'h010] <= 32'h8C220004;
         mem[10'h080] <= 32'h12F40078;
         init_done    <= 1'b1;
      end else if (!sram_ce_n && !sram_we_n) begin
         for (int b = 0; b < 4; b++)
            if (!sram_be_n[b]) mem[sram_addr[9:0]][8*b +: 8] <= sram_bus[8*b +: 8];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_vec(input int idx, input vec_t v);
      int lat = 0, oe_cnt = 0, we_cnt = 0;
      int stall_bad = 0, bus_bad = 0, be_bad = 0, addr_bad = 0, edge_bad = 0;
      @(negedge clk);
      ce = 1'b1; we = v.we; aluop = v.aluop; addr = v.addr; wdata = v.data;
      #1 check($sformatf("v%0d stall_accept", idx), 32'(stall), 32'd1);
      @(posedge clk);
      for (int n = 1; n <= BUDGET; n++) begin
         @(negedge clk);
         if (n == 1) ce = 1'b0;
         if (valid) begin
            if (stall) stall_bad++;
            lat = n;
            break;
         end
         if (!stall) stall_bad++;
         if (sram_be_n !== v.exp_be) be_bad++;
         if (sram_addr !== v.addr[21:2]) addr_bad++;
         if (!sram_we_n) we_cnt++;
         if (!sram_oe_n) begin
            oe_cnt++;
            if (sram_bus !== mem[v.addr[11:2]]) bus_bad++;
         end
         if (v.we && (sram_bus !== v.exp_bus)) bus_bad++;
         if (v.we && (n == 1 || n == int'(W) + 2) && !sram_we_n) edge_bad++;
      end
      check($sformatf("v%0d latency", idx), 32'(lat), v.we ? 32'(W + 3) : 32'(W + 1));
      check($sformatf("v%0d data_o", idx), rdata, v.exp_data);
      check($sformatf("v%0d oe_cycles", idx), 32'(oe_cnt), v.we ? 32'd0 : 32'(W));
      check($sformatf("v%0d we_cycles", idx), 32'(we_cnt), v.we ? 32'(W) : 32'd0);
      check($sformatf("v%0d setup_hold", idx), 32'(edge_bad), 32'd0);
      check($sformatf("v%0d stall_bad", idx), 32'(stall_bad), 32'd0);
      check($sformatf("v%0d bus_bad", idx), 32'(bus_bad), 32'd0);
      check($sformatf("v%0d be_bad", idx), 32'(be_bad), 32'd0);
      check($sformatf("v%0d addr_bad", idx), 32'(addr_bad), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d mem", idx), mem[v.addr[11:2]], v.exp_mem);
      check($sformatf("v%0d idle_valid", idx), 32'(valid), 32'd0);
      check($sformatf("v%0d idle_stall", idx), 32'(stall), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int v1_n = 0, v2_n = 0, oe2_n = 0, rd_bus_bad = 0, we_low = 0;
      logic [31:0] v1_d = '0, v2_d = '0;
      logic [AW-1:0] addr2 = '0;
      logic prev_oe_n = 1'b1;

      //            we    op      addr          data          exp_data      exp_bus       be       exp_mem
      vecs[0]  = '{1'b0, OP_LW,  32'h00000040, 32'h0,        32'h8C220004, 32'h0,        4'h0,    32'h8C220004};
      vecs[1]  = '{1'b1, OP_SW,  32'h00000100, 32'hDEADBEEF, 32'h8C220004, 32'hDEADBEEF, 4'h0,    32'hDEADBEEF};
      vecs[2]  = '{1'b0, OP_LW,  32'h00000100, 32'h0,        32'hDEADBEEF, 32'h0,        4'h0,    32'hDEADBEEF};
      vecs[3]  = '{1'b1, OP_SB,  32'h00000103, 32'h000000A5, 32'hDEADBEEF, 32'hA5A5A5A5, 4'b0111, 32'hA5ADBEEF};
      vecs[4]  = '{1'b0, OP_LW,  32'h00000103, 32'h0,        32'hA5ADBEEF, 32'h0,        4'h0,    32'hA5ADBEEF};
      vecs[5]  = '{1'b0, OP_LB,  32'h00000202, 32'h0,        32'hFFFFFFF4, 32'h0,        4'h0,    32'h12F40078};
      vecs[6]  = '{1'b0, OP_LBU, 32'h00000202, 32'h0,        32'h000000F4, 32'h0,        4'h0,    32'h12F40078};
      vecs[7]  = '{1'b0, OP_LB,  32'h00000200, 32'h0,        32'h00000078, 32'h0,        4'h0,    32'h12F40078};
      vecs[8]  = '{1'b0, OP_LB,  32'h00000203, 32'h0,        32'h00000012, 32'h0,        4'h0,    32'h12F40078};
      vecs[9]  = '{1'b1, OP_SB,  32'h00000201, 32'h12345633, 32'h00000012, 32'h33333333, 4'b1101, 32'h12F43378};
      vecs[10] = '{1'b0, OP_LBU, 32'h00000201, 32'h0,        32'h00000033, 32'h0,        4'h0,    32'h12F43378};
      vecs[11] = '{1'b0, 8'h25,  32'h00000200, 32'h0,        32'h12F43378, 32'h0,        4'h0,    32'h12F43378};
      vecs[12] = '{1'b1, 8'h00,  32'h00000202, 32'hCAFEF00D, 32'h12F43378, 32'hCAFEF00D, 4'h0,    32'hCAFEF00D};
      vecs[13] = '{1'b0, OP_LBU, 32'h00000203, 32'h0,        32'h000000CA, 32'h0,        4'h0,    32'hCAFEF00D};
      vecs[14] = '{1'b0, OP_LB,  32'h00000201, 32'h0,        32'hFFFFFFF0, 32'h0,        4'h0,    32'hCAFEF00D};

      rst = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; wdata = '0; aluop = '0;
      repeat (3) @(negedge clk);
      probe = 1'b1;
      #1;
      check("rst ce_n", 32'(sram_ce_n), 32'd1);
      check("rst oe_n", 32'(sram_oe_n), 32'd1);
      check("rst we_n", 32'(sram_we_n), 32'd1);
      check("rst be_n", 32'(sram_be_n), 32'hF);
      check("rst addr", 32'(sram_addr), 32'd0);
      check("rst bus_released", sram_bus, 32'h0);
      check("rst valid", 32'(valid), 32'd0);
      check("rst data_o", rdata, 32'h0);
      check("rst stall", 32'(stall), 32'd0);
      @(negedge clk);
      probe = 1'b0;
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 15; i++) do_vec(i, vecs[i]);

      // Back-to-back fetches with ce held: second acceptance W+2 cycles after the first.
      @(negedge clk);
      ce = 1'b1; we = 1'b0; aluop = OP_LW; addr = 32'h0;
      @(posedge clk);
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (n == 1) addr = 32'h4;
         if (valid && v1_n == 0) begin v1_n = n; v1_d = rdata; end
         else if (valid && v2_n == 0) begin v2_n = n; v2_d = rdata; end
         if (!sram_oe_n && prev_oe_n && n > 1 && oe2_n == 0) begin
            oe2_n = n; addr2 = sram_addr;
         end
         if (!sram_oe_n && (sram_bus !== mem[sram_addr[9:0]])) rd_bus_bad++;
         if (!sram_we_n) we_low++;
         if (n == 3) check("b2b stall_done", 32'(stall), 32'd0);
         if (n == 4) check("b2b stall_accept2", 32'(stall), 32'd1);
         prev_oe_n = sram_oe_n;
         if (n == 5) ce = 1'b0;
      end
      check("b2b valid1_cycle", 32'(v1_n), 32'(W + 1));
      check("b2b data1", v1_d, 32'h3C010001);
      check("b2b second_accept", 32'(oe2_n - 1), 32'(W + 2));
      check("b2b addr2", 32'(addr2), 32'd1);
      check("b2b valid2_cycle", 32'(v2_n), 32'(2 * W + 3));
      check("b2b data2", v2_d, 32'h34210002);
      check("b2b bus_clean", 32'(rd_bus_bad), 32'd0);
      check("b2b no_write", 32'(we_low), 32'd0);

      // Reset asserted during the write pulse.
      @(negedge clk);
      ce = 1'b1; we = 1'b1; aluop = OP_SW; addr = 32'h300; wdata = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      ce = 1'b0;
      check("rw setup_we_n", 32'(sram_we_n), 32'd1);
      check("rw setup_bus", sram_bus, 32'h12345678);
      @(negedge clk);
      check("rw pulse_we_n", 32'(sram_we_n), 32'd0);
      rst = 1'b0;
      probe = 1'b1;
      #1;
      check("rw we_n", 32'(sram_we_n), 32'd1);
      check("rw ce_n", 32'(sram_ce_n), 32'd1);
      check("rw be_n", 32'(sram_be_n), 32'hF);
      check("rw bus_released", sram_bus, 32'h0);
      check("rw data_o", rdata, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      probe = 1'b0;
      @(negedge clk);
      check("rw post_valid", 32'(valid), 32'd0);
      check("rw post_stall", 32'(stall), 32'd0);
      check("rw post_data_o", rdata, 32'h0);
      do_vec(99, vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rom_sram_ctrl.md
# rom_sram_ctrl

Memory-side stage directly downstream of the PC stage. It consumes the registered request (`addr`, `ce`, `we`, write data, `aluop`) that the PC stage presents to "ROM" and turns it into a multi-cycle access on the external asynchronous 32-bit SRAM. It returns a fetched instruction or a byte/word load result, and holds the pipeline through CTRL with a stall request while the access is in flight. Instruction fetches and EX-issued loads/stores share this single port.

## Interface
- `WAIT_CYCLES`, default 2: SRAM strobe-low cycles per access; legal range 1..15.
- `SRAM_AW`, default 20: SRAM word-address width.
- `clk`  in  1: sole clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `ce_i`  in  1: request valid, from PC stage `ce_o`.
- `we_i`  in  1: 1 = store, 0 = fetch/load.
- `addr_i`  in  32: byte address.
- `data_i`  in  32: store data.
- `aluop_i`  in  `AluOpBus`: matched against `EXE_LB_OP`, `EXE_LBU_OP`, `EXE_SB_OP`; every other code is a full-word access.
- `data_o`  out  32: instruction / load result.
- `valid_o`  out  1: one-cycle pulse; `data_o` valid (reads) or store complete.
- `stall_req_o`  out  1: stall request to CTRL.
- `sram_addr_o`  out  `SRAM_AW`: equals `addr_i[SRAM_AW+1:2]`.
- `sram_data_io`  inout  32: SRAM data bus.
- `sram_ce_n_o`, `sram_oe_n_o`, `sram_we_n_o`  out  1 each: active-low strobes.
- `sram_be_n_o`  out  4: active-low byte enables; lane 0 is bits 7:0.

## Operation
- States: `IDLE`, `RD`, `WR_SETUP`, `WR_PULSE`, `WR_HOLD`, `DONE`.
- Acceptance
  - Only in `IDLE` with `ce_i`=1.
  - The block latches `addr_i`, `we_i`, `data_i` and the decoded lane and extend mode at that edge.
  - It then moves to `RD` (`we_i`=0) or `WR_SETUP` (`we_i`=1).
  - The 4-bit wait counter loads `WAIT_CYCLES-1`.
- `RD`
  - `ce_n`=0, `oe_n`=0, `we_n`=1, bus released (hi-Z).
  - The counter decrements each cycle.
  - On the edge where the counter is 0, the block captures `sram_data_io` and moves to `DONE`.
- `WR_SETUP`: one cycle. Address, `be_n` and data are driven; `ce_n`=0, `we_n`=1.
- `WR_PULSE`: `WAIT_CYCLES` cycles with `we_n`=0 and data driven.
- `WR_HOLD`: one cycle with `we_n`=1 and data still driven. Then `DONE`.
- `DONE`: `valid_o`=1 and strobes inactive. Always goes to `IDLE`; no acceptance in `DONE`.
- Byte handling (lane = latched `addr[1:0]`)
  - LB: `data_o` = selected byte, sign-extended.
  - LBU: selected byte, zero-extended.
  - SB: `data_i[7:0]` replicated to all four lanes; only that lane's `be_n` is low.
  - Full word: `be_n`=4'h0 and `addr[1:0]` is ignored; no misalignment check.
- `stall_req_o` = (`IDLE` & `ce_i`) | `RD` | `WR_*`.
  - Combinational, so CTRL freezes the PC stage in the acceptance cycle itself.
  - 0 in `DONE` and in `IDLE` with `ce_i`=0.
- Bus drive: `sram_data_io` is driven only in `WR_*` states, hi-Z otherwise, so the bus is never contended with SRAM output.
- An access in progress is never aborted; CTRL flush does not reach this block.
- `data_o` holds its last value until the next read completes; stores do not change it.

## Timing
- Reset values (held while `rst`=0, applied asynchronously):
  - State `IDLE`.
  - `data_o`=0, `valid_o`=0.
  - `sram_ce_n`/`oe_n`/`we_n`=1, `sram_be_n`=4'hF, `sram_addr`=0, data bus hi-Z.
- Read: accepted at edge k; data captured at edge k+`WAIT_CYCLES`; `valid_o` high during cycle k+`WAIT_CYCLES`+1.
- Write: accepted at edge k; `valid_o` high during cycle k+`WAIT_CYCLES`+3.
- Back-to-back: the next request is accepted at the edge leaving `DONE`'s following `IDLE` cycle.
  - Read throughput: one access every `WAIT_CYCLES`+2 cycles.
- Reset mid-access: strobes go inactive and the bus goes hi-Z immediately, not at the next edge. A partial write is permitted.

## Test plan
- Read, `WAIT_CYCLES`=2: SRAM word 0x00010 = 0x8C220004; `ce_i`=1, `addr_i`=0x40, `we_i`=0 → `sram_addr`=0x10 and `oe_n` low for 2 cycles; `valid_o` pulses 3 cycles after acceptance with `data_o`=0x8C220004; `stall_req_o` high for 3 cycles then low.
- SW: `addr_i`=0x100, `data_i`=0xDEADBEEF → `we_n` low exactly 2 cycles, with one setup cycle and one hold cycle around it; `be_n`=0x0; the word reads back 0xDEADBEEF.
- SB: `addr_i`=0x103, `data_i`=0x000000A5 → bus carries 0xA5A5A5A5, `be_n`=4'b0111; only bits 31:24 change.
- LB/LBU: SRAM word 0x12F40078, `addr_i`=0x...2 → LB gives 0xFFFFFFF4, LBU gives 0x000000F4.
- Back-to-back fetches at 0x0 and 0x4 with `ce_i` held → second acceptance 4 cycles after the first; bus never driven during reads.
- Reset asserted in `WR_PULSE` → `we_n`=1, `be_n`=0xF and bus hi-Z before the next edge; after release the block is in `IDLE`, `valid_o`=0 and `data_o`=0.
